// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch slice.
// Optional feature macro: FETCH_BREAKPOINT_EN (adds the BREAK fetch state).
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned OPC_W  = 5;

  localparam logic [OPC_W-1:0]  OPC_STP  = 5'b11111;
  localparam logic [OPC_W-1:0]  OPC_NOP  = 5'b00000;
  localparam logic [WORD_W-1:0] NOP_WORD = 16'h0000;

  typedef enum logic [2:0] {
    BOOT,
    RUN,
    STALL,
    HALT
`ifdef FETCH_BREAKPOINT_EN
    , BREAK
`endif
  } fetch_state_t;

  // True when the opcode field of an instruction word is STP.
  function automatic logic is_stp(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: OPC_W] == OPC_STP;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Decoder / instruction-RAM bundle for instr_fetch_unit.
//   master: the fetch unit (drives RAM addresses and decoder inputs)
//   slave : the surrounding decoder + RAM
// Signals: stall, dec_addr1/2, new_pc, pc_sload, cnt_en, mem_q1/2 toward the
// fetch unit; mem_addr1/2, instr, n_word, pc, instr_valid, halted from it.
// FETCH_BREAKPOINT_EN adds bp_addr, bp_arm, bp_resume (in) and bp_hit (out).
interface instr_fetch_unit_if;
  import cpu_pkg::*;

  logic              stall;
  logic [ADDR_W-1:0] dec_addr1;
  logic [ADDR_W-1:0] dec_addr2;
  logic [ADDR_W-1:0] new_pc;
  logic              pc_sload;
  logic              cnt_en;
  logic [WORD_W-1:0] mem_q1;
  logic [WORD_W-1:0] mem_q2;
  logic [ADDR_W-1:0] mem_addr1;
  logic [ADDR_W-1:0] mem_addr2;
  logic [WORD_W-1:0] instr;
  logic [WORD_W-1:0] n_word;
  logic [ADDR_W-1:0] pc;
  logic              instr_valid;
  logic              halted;
`ifdef FETCH_BREAKPOINT_EN
  logic [ADDR_W-1:0] bp_addr;
  logic              bp_arm;
  logic              bp_resume;
  logic              bp_hit;

  modport master (
    input  stall, dec_addr1, dec_addr2, new_pc, pc_sload, cnt_en, mem_q1, mem_q2,
    input  bp_addr, bp_arm, bp_resume,
    output mem_addr1, mem_addr2, instr, n_word, pc, instr_valid, halted, bp_hit
  );

  modport slave (
    output stall, dec_addr1, dec_addr2, new_pc, pc_sload, cnt_en, mem_q1, mem_q2,
    output bp_addr, bp_arm, bp_resume,
    input  mem_addr1, mem_addr2, instr, n_word, pc, instr_valid, halted, bp_hit
  );
`else
  modport master (
    input  stall, dec_addr1, dec_addr2, new_pc, pc_sload, cnt_en, mem_q1, mem_q2,
    output mem_addr1, mem_addr2, instr, n_word, pc, instr_valid, halted
  );

  modport slave (
    output stall, dec_addr1, dec_addr2, new_pc, pc_sload, cnt_en, mem_q1, mem_q2,
    input  mem_addr1, mem_addr2, instr, n_word, pc, instr_valid, halted
  );
`endif

endinterface

// File: rtl/pc_reg.sv
// Program counter register: load has priority over increment, 16-bit wrap.
// Ports: clk, rst_n (async active-low), sload, cnt_en, load_val -> pc.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_VAL = 16'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sload,
  input  logic              cnt_en,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VAL;
    end else if (sload) begin
      pc <= load_val;
    end else if (cnt_en) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC, boot fetch, stall freeze and STP halt,
// sitting between the decoder and a dual-port 1-cycle-latency instruction RAM.
// Ports: clk, rst_n (async active-low), bus (instr_fetch_unit_if.master).
// Optional: define FETCH_BREAKPOINT_EN for the address breakpoint (BREAK state).
module instr_fetch_unit #(
  parameter logic [cpu_pkg::ADDR_W-1:0] RESET_PC = 16'h0000,
  parameter logic [cpu_pkg::WORD_W-1:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
);
  import cpu_pkg::*;

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] addr1_q;
  logic [ADDR_W-1:0] addr2_q;
  logic              bp_cond_c;
  logic              consume_c;

`ifdef FETCH_BREAKPOINT_EN
  assign bp_cond_c  = bus.bp_arm && (bus.dec_addr1 == bus.bp_addr);
  assign bus.bp_hit = (state == BREAK);
`else
  assign bp_cond_c  = 1'b0;
`endif

  // The presented instruction is consumed only in RUN without a pending
  // stall (a breakpoint overrides the stall); otherwise the RAM is re-driven
  // with the address of the word on display so that word survives the freeze.
  assign consume_c = (state == RUN) && (!bus.stall || bp_cond_c);

  assign bus.mem_addr1   = consume_c ? bus.dec_addr1 : addr1_q;
  assign bus.mem_addr2   = consume_c ? bus.dec_addr2 : addr2_q;
  assign bus.instr_valid = (state == RUN);
  assign bus.halted      = (state == HALT);
  assign bus.instr       = bus.instr_valid ? bus.mem_q1 : NOP_WORD;
  assign bus.n_word      = bus.instr_valid ? bus.mem_q2 : WORD_W'(0);

  // State register plus the address last sampled by the RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BOOT;
      addr1_q <= RESET_PC;
      addr2_q <= RESET_PC + ADDR_W'(1);
    end else begin
      state   <= state_nxt;
      addr1_q <= bus.mem_addr1;
      addr2_q <= bus.mem_addr2;
    end
  end

  // Next-state logic; a stall defers STP, a breakpoint overrides the stall.
  always_comb begin
    state_nxt = state;
    case (state)
      BOOT:  state_nxt = RUN;
      RUN: begin
        if (is_stp(bus.mem_q1) && !bus.stall) begin
          state_nxt = HALT;
`ifdef FETCH_BREAKPOINT_EN
        end else if (bp_cond_c) begin
          state_nxt = BREAK;
`endif
        end else if (bus.stall) begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (!bus.stall) begin
          state_nxt = RUN;
        end
      end
      HALT:  state_nxt = HALT;
`ifdef FETCH_BREAKPOINT_EN
      BREAK: begin
        if (bus.bp_resume) begin
          state_nxt = RUN;
        end
      end
`endif
      default: state_nxt = BOOT;
    endcase
  end

  pc_reg #(
    .RESET_VAL (RESET_PC + ADDR_W'(1))
  ) u_pc_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .sload    (consume_c && bus.pc_sload),
    .cnt_en   (consume_c && bus.cnt_en),
    .load_val (bus.new_pc),
    .pc       (bus.pc)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: the bench acts as decoder and as a
// dual-port synchronous instruction RAM.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [15:0] ram [0:65535];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (16'h0000),
    .NOP_WORD (16'h0000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM, 1-cycle read latency on both ports.
  always @(posedge clk) begin
    bus.mem_q1 <= ram[bus.mem_addr1];
    bus.mem_q2 <= ram[bus.mem_addr2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a1, input logic sl, input logic ce,
                       input logic [15:0] npc);
    bus.dec_addr1 = a1;
    bus.dec_addr2 = a1 + 16'd1;
    bus.pc_sload  = sl;
    bus.cnt_en    = ce;
    bus.new_pc    = npc;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr1"}, bus.mem_addr1, 16'h0000);
    chk({tag, "_addr2"}, bus.mem_addr2, 16'h0001);
    chk({tag, "_pc"}, bus.pc, 16'h0001);
    chk({tag, "_valid"}, 16'(bus.instr_valid), 16'h0000);
    chk({tag, "_halted"}, 16'(bus.halted), 16'h0000);
    chk({tag, "_instr"}, bus.instr, 16'h0000);
    chk({tag, "_nword"}, bus.n_word, 16'h0000);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.stall = 1'b0;
    drive(16'h1234, 1'b0, 1'b1, 16'h0000);
`ifdef FETCH_BREAKPOINT_EN
    bus.bp_addr   = 16'h0000;
    bus.bp_arm    = 1'b0;
    bus.bp_resume = 1'b0;
`endif
    for (int i = 0; i < 65536; i++) ram[i] = {5'b00100, 11'(i)};
    ram[16'h0000] = 16'h0000;
    ram[16'h0001] = 16'h0000;
    ram[16'h0002] = 16'h2ABC;
    ram[16'h0060] = 16'hF800;

    // Reset and boot
    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;
    settle();
    chk("boot_addr1", bus.mem_addr1, 16'h0000);
    chk("boot_valid", 16'(bus.instr_valid), 16'h0000);
    tick();
    chk("run1_valid", 16'(bus.instr_valid), 16'h0001);
    chk("run1_pc", bus.pc, 16'h0001);
    chk("run1_instr", bus.instr, 16'h0000);
    drive(16'h0001, 1'b0, 1'b1, 16'h0000);
    settle();
    chk("run1_addr1", bus.mem_addr1, 16'h0001);
    chk("run1_addr2", bus.mem_addr2, 16'h0002);
    tick();
    chk("run2_pc", bus.pc, 16'h0002);
    drive(16'h0002, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("run3_instr", bus.instr, 16'h2ABC);
    chk("run3_nword", bus.n_word, 16'h2003);
    chk("run3_pc", bus.pc, 16'h0003);

    // CALL at 0 with N = 0x0040
    rst_n = 1'b0;
    settle();
    chk_reset("rst2");
    ram[16'h0000] = 16'h6000;
    ram[16'h0001] = 16'h0040;
    drive(16'h1234, 1'b0, 1'b0, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("call_instr", bus.instr, 16'h6000);
    chk("call_nword", bus.n_word, 16'h0040);
    drive(16'h0040, 1'b1, 1'b0, 16'h0041);
    settle();
    chk("call_addr1", bus.mem_addr1, 16'h0040);
    chk("call_addr2", bus.mem_addr2, 16'h0041);
    tick();
    chk("call_pc", bus.pc, 16'h0041);
    chk("call_tgt_instr", bus.instr, 16'h2040);
    chk("call_tgt_nword", bus.n_word, 16'h2041);

    // Strobe priority and 16-bit wrap
    drive(16'h0042, 1'b1, 1'b1, 16'hFFFF);
    tick();
    chk("prio_pc", bus.pc, 16'hFFFF);
    drive(16'h0043, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("wrap_pc", bus.pc, 16'h0000);
    drive(16'h0044, 1'b0, 1'b0, 16'h5555);
    tick();
    chk("hold_pc", bus.pc, 16'h0000);
    chk("hold_instr", bus.instr, 16'h2044);

    // Three-cycle stall
    drive(16'h0050, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("prestall_instr", bus.instr, 16'h2050);
    chk("prestall_pc", bus.pc, 16'h0001);
    bus.stall = 1'b1;
    drive(16'h0060, 1'b0, 1'b1, 16'h0000);
    settle();
    chk("stallreq_addr1", bus.mem_addr1, 16'h0050);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_valid", 16'(bus.instr_valid), 16'h0000);
      chk("stall_instr", bus.instr, 16'h0000);
      chk("stall_addr1", bus.mem_addr1, 16'h0050);
      chk("stall_pc", bus.pc, 16'h0001);
    end
    bus.stall = 1'b0;
    tick();
    chk("unstall_valid", 16'(bus.instr_valid), 16'h0001);
    chk("unstall_instr", bus.instr, 16'h2050);
    chk("unstall_pc", bus.pc, 16'h0001);
    tick();
    chk("stp_instr", bus.instr, 16'hF800);
    chk("stp_pc", bus.pc, 16'h0002);

    // STP with stall in the same cycle, then STP alone
    bus.stall = 1'b1;
    drive(16'h0070, 1'b0, 1'b0, 16'h0000);
    tick();
    chk("stpstall_halted", 16'(bus.halted), 16'h0000);
    chk("stpstall_valid", 16'(bus.instr_valid), 16'h0000);
    bus.stall = 1'b0;
    tick();
    chk("stp_again_instr", bus.instr, 16'hF800);
    chk("stp_again_halted", 16'(bus.halted), 16'h0000);
    tick();
    chk("halt_halted", 16'(bus.halted), 16'h0001);
    chk("halt_valid", 16'(bus.instr_valid), 16'h0000);
    for (int k = 0; k < 20; k++) begin
      drive(16'h0099 + 16'(k), 1'b1, 1'b1, 16'h1234);
      bus.stall = 1'(k);
      tick();
      chk("halt_hold_halted", 16'(bus.halted), 16'h0001);
      chk("halt_hold_pc", bus.pc, 16'h0002);
      chk("halt_hold_addr1", bus.mem_addr1, 16'h0070);
      chk("halt_hold_valid", 16'(bus.instr_valid), 16'h0000);
    end
    bus.stall = 1'b0;

    // Async reset out of HALT, then reset during a CALL
    rst_n = 1'b0;
    settle();
    chk_reset("rst3");
    drive(16'h1234, 1'b0, 1'b0, 16'h0000);
    tick();
    rst_n = 1'b1;
    tick();
    chk("reboot_instr", bus.instr, 16'h6000);
    drive(16'h0040, 1'b1, 1'b0, 16'h0041);
    settle();
    chk("midcall_addr1", bus.mem_addr1, 16'h0040);
    rst_n = 1'b0;
    settle();
    chk_reset("rst4");
    tick();
    chk("rst4_pc_held", bus.pc, 16'h0001);
    rst_n = 1'b1;
    settle();
    chk("reboot2_addr1", bus.mem_addr1, 16'h0000);
    chk("reboot2_valid", 16'(bus.instr_valid), 16'h0000);
    tick();
    chk("reboot2_run_valid", 16'(bus.instr_valid), 16'h0001);
    chk("reboot2_instr", bus.instr, 16'h6000);
    chk("reboot2_pc", bus.pc, 16'h0001);

`ifdef FETCH_BREAKPOINT_EN
    // Breakpoint on 0x0003
    drive(16'h0002, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("bp_pre_instr", bus.instr, 16'h2ABC);
    bus.bp_addr = 16'h0003;
    bus.bp_arm  = 1'b1;
    drive(16'h0003, 1'b0, 1'b1, 16'h0000);
    tick();
    chk("bp_hit", 16'(bus.bp_hit), 16'h0001);
    chk("bp_valid", 16'(bus.instr_valid), 16'h0000);
    chk("bp_pc", bus.pc, 16'h0003);
    drive(16'h0004, 1'b0, 1'b1, 16'h0000);
    bus.bp_resume = 1'b1;
    tick();
    bus.bp_resume = 1'b0;
    chk("bp_resume_hit", 16'(bus.bp_hit), 16'h0000);
    chk("bp_resume_valid", 16'(bus.instr_valid), 16'h0001);
    chk("bp_resume_instr", bus.instr, 16'h2003);
    chk("bp_resume_pc", bus.pc, 16'h0003);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
